// File: rtl/debug_capture_ctrl.sv
// Logic-analyser style capture controller: records samples into an external ring buffer,
// stops POST_TRIGGER samples after a trigger, then streams the buffer out byte-wise, oldest first.
module debug_capture_ctrl #(
    parameter int CAPTURE_WIDTH_BITS = 88,
    parameter int CAPTURE_SIZE       = 128,
    parameter int POST_TRIGGER       = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CAPTURE_WIDTH_BITS-1:0]   capture_data,
    input  logic                            capture_enable,
    input  logic                            trigger,
    input  logic                            rearm,
    output logic                            buf_we,
    output logic [$clog2(CAPTURE_SIZE)-1:0] buf_waddr,
    output logic [CAPTURE_WIDTH_BITS-1:0]   buf_wdata,
    output logic [$clog2(CAPTURE_SIZE)-1:0] buf_raddr,
    input  logic [CAPTURE_WIDTH_BITS-1:0]   buf_rdata,
    output logic [7:0]                      tx_byte,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            triggered,
    output logic                            dump_active,
    output logic                            done
);
    localparam int BYTES = (CAPTURE_WIDTH_BITS + 7) / 8;
    localparam int SW    = BYTES * 8;
    localparam int AW    = $clog2(CAPTURE_SIZE);
    localparam int CW    = $clog2(CAPTURE_SIZE + 1);
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_CAPTURE, S_POST, S_READ, S_LOAD, S_SEND, S_DONE
    } state_t;

    state_t          state, next_state;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            wrapped;
    logic [CW-1:0]   post_cnt, remaining;
    logic [SW-1:0]   shreg;
    logic [BW-1:0]   byte_idx;
    logic            last_byte, wrap_nxt;

    assign buf_we      = capture_enable && (state == S_CAPTURE || state == S_POST);
    assign buf_waddr   = wr_ptr;
    assign buf_wdata   = capture_data;
    assign buf_raddr   = rd_ptr;
    assign tx_valid    = (state == S_SEND);
    assign tx_byte     = shreg[7:0];
    assign triggered   = (state == S_POST) || (state == S_READ) || (state == S_LOAD) || (state == S_SEND);
    assign dump_active = (state == S_READ) || (state == S_LOAD) || (state == S_SEND);
    assign done        = (state == S_DONE);
    assign last_byte   = (byte_idx == BW'(BYTES - 1));
    assign wrap_nxt    = wrapped || (wr_ptr == AW'(CAPTURE_SIZE - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_CAPTURE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_CAPTURE: if (trigger) next_state = S_POST;
            S_POST:    if (buf_we && post_cnt == CW'(1)) next_state = S_READ;
            S_READ:    next_state = S_LOAD;
            S_LOAD:    next_state = S_SEND;
            S_SEND:    if (tx_ready && last_byte) next_state = (remaining != '0) ? S_READ : S_DONE;
            S_DONE:    if (rearm) next_state = S_CAPTURE;
            default:   next_state = S_CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wrapped   <= 1'b0;
            post_cnt  <= '0;
            remaining <= '0;
            shreg     <= '0;
            byte_idx  <= '0;
        end else begin
            if (buf_we) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (wr_ptr == AW'(CAPTURE_SIZE - 1)) wrapped <= 1'b1;
            end
            case (state)
                S_CAPTURE: if (trigger) post_cnt <= CW'(POST_TRIGGER);
                S_POST: if (buf_we) begin
                    post_cnt <= post_cnt - CW'(1);
                    // Final post-trigger write: oldest sample is the next write slot once wrapped.
                    if (post_cnt == CW'(1)) begin
                        if (wrap_nxt) begin
                            rd_ptr    <= wr_ptr + AW'(1);
                            remaining <= CW'(CAPTURE_SIZE);
                        end else begin
                            rd_ptr    <= '0;
                            remaining <= CW'(wr_ptr) + CW'(1);
                        end
                    end
                end
                S_LOAD: begin
                    shreg     <= SW'(buf_rdata);
                    byte_idx  <= '0;
                    rd_ptr    <= rd_ptr + AW'(1);
                    remaining <= remaining - CW'(1);
                end
                S_SEND: if (tx_ready) begin
                    shreg    <= shreg >> 8;
                    byte_idx <= byte_idx + BW'(1);
                end
                S_DONE: if (rearm) begin
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    wrapped   <= 1'b0;
                    post_cnt  <= '0;
                    remaining <= '0;
                    byte_idx  <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_capture_ctrl.sv
// Scoreboard bench for debug_capture_ctrl: a sample-list model predicts the dumped byte stream,
// an independent monitor checks every accepted byte and the hold-while-stalled rule.
module tb_debug_capture_ctrl;
    localparam int W = 12, SIZE = 8, PT = 3, BYTES = 2;

    logic          clk = 0, reset = 1;
    logic [W-1:0]  capture_data = '0, buf_wdata, buf_rdata;
    logic          capture_enable = 0, trigger = 0, rearm = 0, tx_ready = 0;
    logic          buf_we, tx_valid, triggered, dump_active, done;
    logic [2:0]    buf_waddr, buf_raddr;
    logic [7:0]    tx_byte;

    debug_capture_ctrl #(.CAPTURE_WIDTH_BITS(W), .CAPTURE_SIZE(SIZE), .POST_TRIGGER(PT)) dut (
        .clk(clk), .reset(reset), .capture_data(capture_data), .capture_enable(capture_enable),
        .trigger(trigger), .rearm(rearm), .buf_we(buf_we), .buf_waddr(buf_waddr),
        .buf_wdata(buf_wdata), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .tx_byte(tx_byte),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .triggered(triggered),
        .dump_active(dump_active), .done(done));

    always #5 clk = ~clk;

    // Synchronous-read capture RAM
    logic [W-1:0] mem [SIZE];
    always @(posedge clk) begin
        if (buf_we) mem[buf_waddr] <= buf_wdata;
        buf_rdata <= mem[buf_raddr];
    end

    typedef enum {P_CAP, P_POST, P_DUMP, P_DONE} phase_t;
    phase_t       ph = P_CAP;
    int           post_left = 0;
    logic [W-1:0] samples[$];
    logic [7:0]   exp_q[$];
    int           vectors = 0, miscompares = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected dump: the newest min(n, SIZE) samples, oldest first, low byte first
    task automatic build_dump();
        int n;
        logic [15:0] v;
        n = (samples.size() > SIZE) ? SIZE : samples.size();
        for (int i = samples.size() - n; i < samples.size(); i++) begin
            v = 16'(samples[i]);
            for (int b = 0; b < BYTES; b++) exp_q.push_back(v[8*b +: 8]);
        end
    endtask

    task automatic step(logic ce, logic trig, logic [W-1:0] d, logic rr, logic rdy);
        logic       exp_we;
        logic [2:0] exp_addr;
        @(posedge clk); #1;
        reset = 0; capture_enable = ce; trigger = trig; capture_data = d; rearm = rr; tx_ready = rdy;
        exp_we   = ce && (ph == P_CAP || ph == P_POST);
        exp_addr = 3'(samples.size() % SIZE);
        @(negedge clk);
        chk("buf_we", buf_we, exp_we);
        if (exp_we) begin
            chk("buf_waddr", buf_waddr, exp_addr);
            chk("buf_wdata", buf_wdata, d);
            samples.push_back(d);
        end
        if (ph == P_CAP && trig) begin
            ph = P_POST; post_left = PT;
        end else if (ph == P_POST && exp_we) begin
            post_left--;
            if (post_left == 0) begin ph = P_DUMP; build_dump(); end
        end else if (ph == P_DONE && rr) begin
            ph = P_CAP; samples.delete();
        end
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset = 1; capture_enable = 1'($urandom); trigger = 1'($urandom);
            capture_data = W'($urandom); rearm = 1'($urandom); tx_ready = 1'($urandom);
            @(negedge clk);
            if (i >= 1) begin
                chk("rst_tx_valid", tx_valid, 0);
                chk("rst_tx_byte", tx_byte, 0);
                chk("rst_triggered", triggered, 0);
                chk("rst_dump_active", dump_active, 0);
                chk("rst_done", done, 0);
                chk("rst_raddr", buf_raddr, 0);
                chk("rst_waddr", buf_waddr, 0);
                chk("rst_we", buf_we, capture_enable);
                chk("rst_wdata", buf_wdata, capture_data);
            end
        end
        ph = P_CAP; samples.delete(); exp_q.delete();
    endtask

    task automatic wait_done(int bound, bit always_rdy);
        int n = 0;
        while (!done && n < bound) begin
            step(1'($urandom), 1'($urandom), W'($urandom), 0, always_rdy ? 1'b1 : 1'($urandom % 3 != 0));
            n++;
        end
        chk("done_reached", done, 1);
        chk("dump_drained", exp_q.size(), 0);
        ph = P_DONE;
    endtask

    // Monitor: compare every accepted byte against the scoreboard; check stall hold
    logic       pv = 0, pr = 0;
    logic [7:0] pb = 0;
    always @(negedge clk) begin
        if (reset) pv = 0;
        else begin
            if (pv && !pr) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_byte", tx_byte, pb);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL tx_extra: got byte %0h expected none", tx_byte);
                end else chk("tx_byte", tx_byte, exp_q.pop_front());
            end
            pv = tx_valid; pr = tx_ready; pb = tx_byte;
        end
    end

    initial begin
        int guard;
        do_reset(2);

        // Short capture, no wrap: 01 00 02 00 ... 05 00
        for (int k = 1; k <= 5; k++) step(1, k == 2, W'(k), 0, 1);
        wait_done(100, 1);
        for (int k = 0; k < 3; k++) step(1'($urandom), 1, W'($urandom), 0, 1);
        step(0, 0, 0, 1, 1);
        step(1, 0, 12'h0AA, 0, 1);

        // Wrapped capture, dump from address 4; 5-cycle stall mid-stream
        do_reset(2);
        for (int k = 1; k <= 12; k++) step(1, k == 9, W'(k), 0, 1);
        step(0, 0, 0, 0, 1);
        chk("dump_start_raddr", buf_raddr, 4);
        chk("dump_start_active", dump_active, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0);
        wait_done(200, 0);

        // Reset in the middle of SEND
        do_reset(2);
        for (int k = 1; k <= 6; k++) step(1, k == 2, W'($urandom), 0, 1);
        guard = 0;
        while (!tx_valid && guard < 20) begin step(0, 0, 0, 0, 0); guard++; end
        chk("send_reached", tx_valid, 1);
        do_reset(2);
        step(1, 0, 12'h123, 0, 1);

        // Randomized trials chained through rearm
        do_reset(2);
        for (int t = 0; t < 6; t++) begin
            guard = 0;
            while (ph != P_DUMP && guard < 200) begin
                step(1'($urandom % 4 != 0), 1'($urandom % (t * 6 + 2) == 0), W'($urandom),
                     1'($urandom % 8 == 0), 1'($urandom));
                guard++;
            end
            chk("dump_entered", ph == P_DUMP, 1);
            wait_done(500, 0);
            for (int k = 0; k < 2; k++) step(1'($urandom), 1'($urandom), W'($urandom), 0, 1'($urandom));
            step(1'($urandom), 0, W'($urandom), 1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/debug_capture_ctrl.md
DEBUG_CAPTURE_CTRL -- requirements
Module: debug_capture_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  CAPTURE_WIDTH_BITS, 88, bits per captured sample
  CAPTURE_SIZE, 128, buffer entries (power of two, >=2)
  POST_TRIGGER, 64, samples stored after trigger (1..CAPTURE_SIZE)
  BYTES = ceil(CAPTURE_WIDTH_BITS/8), derived, bytes per sample on dump.
REQ-002 One clock; reset is synchronous and active-high; ports named clk and reset.
REQ-003 Ports, one per line: name, direction, width, meaning:
  clk  in  1  clock
  reset  in  1  sync active-high reset
  capture_data  in  CAPTURE_WIDTH_BITS  sample to record
  capture_enable  in  1  record capture_data this cycle
  trigger  in  1  trigger event
  rearm  in  1  restart capture from DONE
  buf_we  out  1  buffer write strobe
  buf_waddr  out  log2(CAPTURE_SIZE)  write address
  buf_wdata  out  CAPTURE_WIDTH_BITS  write data
  buf_raddr  out  log2(CAPTURE_SIZE)  read address
  buf_rdata  in  CAPTURE_WIDTH_BITS  read data, valid 1 cycle after buf_raddr
  tx_byte  out  8  byte to UART transmitter
  tx_valid  out  1  tx_byte valid
  tx_ready  in  1  transmitter accepts byte
  triggered  out  1  high in POST and all dump states
  dump_active  out  1  high in READ, LOAD, SEND
  done  out  1  high in DONE

Function
REQ-004 States: CAPTURE, POST, READ, LOAD, SEND, DONE; reset state CAPTURE.
REQ-005 buf_we/buf_waddr/buf_wdata combinational: buf_we = capture_enable in CAPTURE or POST, else 0; buf_waddr = wr_ptr; buf_wdata = capture_data.
REQ-006 Each buf_we cycle: wr_ptr increments modulo CAPTURE_SIZE; wrap to 0 sets sticky wrapped flag.
REQ-007 CAPTURE: trigger loads post counter with POST_TRIGGER, moves to POST; a sample written in the trigger cycle counts as pre-trigger.
REQ-008 POST: each written sample decrements post counter; write taking it to 0 moves to READ next cycle; trigger ignored.
REQ-009 On entering READ from POST: if wrapped, rd_ptr = wr_ptr, remaining = CAPTURE_SIZE; else rd_ptr = 0, remaining = wr_ptr (wr_ptr==0 impossible since POST_TRIGGER>=1).
REQ-010 READ (1 cycle): buf_raddr = rd_ptr; go LOAD.
REQ-011 LOAD (1 cycle): latch buf_rdata into shift register, byte index = 0, increment rd_ptr modulo CAPTURE_SIZE, decrement remaining; go SEND.
REQ-012 SEND: tx_valid = 1, tx_byte = shift register [7:0] (bits above CAPTURE_WIDTH_BITS read as 0); on tx_valid && tx_ready shift right 8, byte index++.
REQ-013 Accepted last byte (index BYTES-1): remaining > 0 -> READ, else DONE.
REQ-014 tx_valid never deasserts and tx_byte never changes while tx_ready low.
REQ-015 Samples dumped oldest first, bytes least-significant first.
REQ-016 DONE: capture_enable, trigger ignored; rearm clears wr_ptr, wrapped, counters, returns to CAPTURE next cycle; rearm ignored elsewhere.
REQ-017 tx_valid 0 outside SEND; buf_raddr = rd_ptr in all states.

Reset
REQ-018 Reset overrides all inputs, any state including mid-dump: next cycle state CAPTURE, wr_ptr=rd_ptr=0, wrapped=0, counters 0, tx_valid=0, tx_byte=0, triggered=dump_active=done=0; buffer contents not cleared.

Verification (CAPTURE_WIDTH_BITS=12, CAPTURE_SIZE=8, POST_TRIGGER=3)
REQ-019 Reset asserted 2 cycles, all inputs toggling -> every output 0 except buf_we/buf_wdata following REQ-005; state CAPTURE.
REQ-020 Samples 0x001..0x005 one per cycle, trigger with 0x002, tx_ready=1 -> tx bytes 01 00 02 00 03 00 04 00 05 00, then done=1.
REQ-021 Samples 0x001..0x00C, trigger with 0x009 -> dump starts buf_raddr=4, values 0x005..0x00C in order (16 bytes).
REQ-022 tx_ready low 5 cycles mid-dump -> tx_valid held 1, tx_byte constant; stream resumes with no loss or duplication.
REQ-023 Reset during SEND -> next cycle tx_valid=0, dump_active=0; new capture starts at buf_waddr=0.
REQ-024 In DONE: trigger/capture_enable pulses -> no buf_we; rearm -> CAPTURE, next sample written at address 0.
